// File: rtl/itl_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : itl_seq_ctrl
//  Brief    : Sequencer for the turbo interleaver/de-interleaver symbol RAM
//             pair and permutation ROM. Per physical block it latches the PB
//             size and ROM table base, writes N symbols at linear addresses
//             (LOAD), issues N read indices 0..N-1 (READ), then drains the
//             fixed RAM/ROM read latency (FLUSH) and pulses done.
//  Options  : define ITL_ABORT_EN to add the i_abort input, which cancels a
//             PB in progress and flags o_err.
//  Revision : 1.0 - initial release
// ============================================================================
module itl_seq_ctrl #(
    parameter int unsigned A_WIDTH   = 12,
    parameter int unsigned N_PB16    = 64,
    parameter int unsigned N_PB136   = 544,
    parameter int unsigned N_PB520   = 2080,
    parameter int unsigned OFS_PB16  = 0,
    parameter int unsigned OFS_PB136 = 64,
    parameter int unsigned OFS_PB520 = 608,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_start,
    input  logic [1:0]         i_pb_size,
    input  logic               i_in_vld,
    output logic               o_in_ready,
    output logic [A_WIDTH-1:0] o_ram_waddr,
    output logic               o_ram_wen,
    output logic [A_WIDTH-1:0] o_ram_raddr,
    output logic               o_ram_rd_en,
    output logic [A_WIDTH-1:0] o_pb_offset,
    output logic               o_out_vld,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
`ifdef ITL_ABORT_EN
    ,
    input  logic               i_abort
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [A_WIDTH-1:0] c_ONE        = A_WIDTH'(1);
    localparam logic [A_WIDTH-1:0] c_NL_PB16    = A_WIDTH'(N_PB16 - 1);
    localparam logic [A_WIDTH-1:0] c_NL_PB136   = A_WIDTH'(N_PB136 - 1);
    localparam logic [A_WIDTH-1:0] c_NL_PB520   = A_WIDTH'(N_PB520 - 1);
    localparam logic [A_WIDTH-1:0] c_OFS_PB16   = A_WIDTH'(OFS_PB16);
    localparam logic [A_WIDTH-1:0] c_OFS_PB136  = A_WIDTH'(OFS_PB136);
    localparam logic [A_WIDTH-1:0] c_OFS_PB520  = A_WIDTH'(OFS_PB520);
    // FLUSH lasts RD_LAT cycles; done is raised so that it lands on the
    // final out_vld. With a single-cycle latency that happens straight out
    // of READ, otherwise one cycle before the last FLUSH cycle.
    localparam logic [A_WIDTH-1:0] c_FL_LAST    = A_WIDTH'(RD_LAT - 1);
    localparam logic [A_WIDTH-1:0] c_DONE_AT    = A_WIDTH'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);
    localparam logic               c_DONE_IN_RD = (RD_LAT == 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READ  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [A_WIDTH-1:0]   r_cnt;
    logic [A_WIDTH-1:0]   r_n_last;
    logic [A_WIDTH-1:0]   r_pb_offset;
    logic [A_WIDTH-1:0]   r_waddr;
    logic [A_WIDTH-1:0]   r_raddr;
    logic                 r_wen;
    logic                 r_rd_en;
    logic                 r_done;
    logic                 r_err;
    logic [RD_LAT-1:0]    r_vld_sr;

    logic [A_WIDTH-1:0]   w_n_last;
    logic [A_WIDTH-1:0]   w_ofs;
    logic                 w_size_ok;
    logic                 w_abort;

`ifdef ITL_ABORT_EN
    assign w_abort = i_abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Decode the requested PB size into last index and ROM table base
    always_comb begin
        w_n_last  = c_NL_PB16;
        w_ofs     = c_OFS_PB16;
        w_size_ok = 1'b1;
        case (i_pb_size)
            2'd0: begin
                w_n_last = c_NL_PB16;
                w_ofs    = c_OFS_PB16;
            end
            2'd1: begin
                w_n_last = c_NL_PB136;
                w_ofs    = c_OFS_PB136;
            end
            2'd2: begin
                w_n_last = c_NL_PB520;
                w_ofs    = c_OFS_PB520;
            end
            default: begin
                w_size_ok = 1'b0;
            end
        endcase
    end

    // Sequencer FSM; all RAM-side strobes and addresses are registered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_n_last    <= '0;
            r_pb_offset <= '0;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_wen       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wen  <= 1'b0;
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_rd_en <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (w_size_ok) begin
                                r_n_last    <= w_n_last;
                                r_pb_offset <= w_ofs;
                                r_cnt       <= '0;
                                r_err       <= 1'b0;
                                r_state     <= S_LOAD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (i_in_vld) begin
                            r_wen   <= 1'b1;
                            r_waddr <= r_cnt;
                            if (r_cnt == r_n_last) begin
                                // First read index is issued the cycle after
                                // the final write handshake.
                                r_cnt   <= '0;
                                r_raddr <= '0;
                                r_rd_en <= 1'b1;
                                r_state <= S_READ;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                    end
                    S_READ: begin
                        // r_cnt tracks the index currently on o_ram_raddr
                        if (r_cnt == r_n_last) begin
                            r_cnt   <= '0;
                            r_rd_en <= 1'b0;
                            r_state <= S_FLUSH;
                            if (c_DONE_IN_RD) begin
                                r_done <= 1'b1;
                            end
                        end else begin
                            r_cnt   <= r_cnt + c_ONE;
                            r_raddr <= r_cnt + c_ONE;
                            r_rd_en <= 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        if (!c_DONE_IN_RD && (r_cnt == c_DONE_AT)) begin
                            r_done <= 1'b1;
                        end
                        if (r_cnt == c_FL_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Output-valid pipeline: o_ram_rd_en delayed by the RAM/ROM read latency
    generate
        if (RD_LAT == 1) begin : g_vld_lat1
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= w_abort ? 1'b0 : r_rd_en;
                end
            end
        end else begin : g_vld_latn
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_vld_sr <= '0;
                end else if (w_abort) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= {r_vld_sr[RD_LAT-2:0], r_rd_en};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_in_ready  = (r_state == S_LOAD);
    assign o_busy      = (r_state != S_IDLE);
    assign o_ram_waddr = r_waddr;
    assign o_ram_wen   = r_wen;
    assign o_ram_raddr = r_raddr;
    assign o_ram_rd_en = r_rd_en;
    assign o_pb_offset = r_pb_offset;
    assign o_out_vld   = r_vld_sr[RD_LAT-1];
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
`default_nettype wire
